pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Generates the per-latch enable/flush pair and the PC enable from memory-hit, load-use, branch-redirect and halt conditions.
- Tracks stale in-flight instruction fetches after a redirect and counts stall cycles for performance readout.
- Sits beside the datapath in the pipelined CPU top level; it is the only source of latch enable/flush.

---
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: drives every latch enable/flush and the PC enable,
// tracks a stale fetch after a taken redirect, and counts stall cycles.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             br_taken_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0] state, state_n;
  logic       redir_pend, redir_n;
  logic       dwait, lu;

  assign dwait = mem_req & ~dhit;
  assign lu    = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    state_n     = state;
    redir_n     = redir_pend;
    if (state == HALT) begin
      state_n = HALT;
    end else if (halt_wb) begin
      state_n = HALT;
    end else if (dwait) begin
      state_n = RUN;
    end else if (br_taken_mem) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      // a fetch still outstanding belongs to the wrong path; remember to drop its word
      redir_n     = ~ihit;
    end else if (lu) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (!ihit) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (redir_pend) begin
        ifid_flush = 1'b1;
        redir_n    = 1'b0;
      end
    end
  end

  assign halted = (state == HALT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_n;
      redir_pend <= redir_n;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cycles <= '0;
    else if ((state == RUN) && !pc_en && !halt_wb && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each step pushes the expected enable/flush vector,
// halted flag and stall count, then the test task pops and compares at the falling edge.
module tb_pipeline_hazard_ctrl;
  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, mem_req, ex_memread, id_uses_rt, br_taken_mem, halt_wb;
  logic [4:0] ex_rt, id_rs, id_rt;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halted;
  logic [15:0] stall_cycles;
  logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_exmem_flush, s_memwb_en, s_halted;
  logic [3:0] s_stall;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .br_taken_mem(br_taken_mem), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .halted(halted), .stall_cycles(stall_cycles));

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .br_taken_mem(br_taken_mem), .halt_wb(halt_wb),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
    .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .exmem_flush(s_exmem_flush),
    .memwb_en(s_memwb_en), .halted(s_halted), .stall_cycles(s_stall));

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
  localparam logic [7:0] NORMAL = 8'b1101_0101;
  localparam logic [7:0] LU     = 8'b0001_1101;
  localparam logic [7:0] FREEZE = 8'b0000_0000;
  localparam logic [7:0] BR     = 8'b1111_1111;
  localparam logic [7:0] NOIHIT = 8'b0111_0101;
  localparam logic [7:0] REDIR  = 8'b1111_0101;

  typedef struct packed {
    logic       ihit, dhit, mem_req, ex_memread;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       id_uses_rt, br, halt;
  } in_t;

  typedef struct packed {
    logic [7:0]  vec;
    logic        halted;
    logic [15:0] stall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_stall;
  bit   m_halted;

  wire [7:0] obs_vec = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};

  function automatic in_t idle(input logic ih);
    in_t i;
    i = '0;
    i.ihit = ih;
    return i;
  endfunction

  task automatic apply(input in_t i);
    ihit = i.ihit; dhit = i.dhit; mem_req = i.mem_req; ex_memread = i.ex_memread;
    ex_rt = i.ex_rt; id_rs = i.id_rs; id_rt = i.id_rt; id_uses_rt = i.id_uses_rt;
    br_taken_mem = i.br; halt_wb = i.halt;
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show for it.
  task automatic drive(input in_t i, input logic [7:0] vec);
    exp_t e;
    @(posedge CLK);
    #1;
    apply(i);
    e.vec    = vec;
    e.halted = m_halted;
    e.stall  = m_stall[15:0];
    sb.push_back(e);
    if (!m_halted && !vec[7] && !i.halt && m_stall < 65535) m_stall++;
    if (i.halt) m_halted = 1'b1;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    nRST = 1'b0;
    apply(idle(1'b1));
    m_stall = 0; m_halted = 1'b0;
    sb.delete();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic run_steps(input string name, input in_t ins[$], input logic [7:0] vecs[$]);
    exp_t e;
    for (int k = 0; k < ins.size(); k++) begin
      drive(ins[k], vecs[k]);
      @(negedge CLK);
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL %s[%0d]: scoreboard empty", name, k);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({obs_vec, halted, stall_cycles} !== {e.vec, e.halted, e.stall}) begin
          errors++;
          $display("FAIL %s[%0d]: got vec=%b halted=%b stall=%0d, want vec=%b halted=%b stall=%0d",
                   name, k, obs_vec, halted, stall_cycles, e.vec, e.halted, e.stall);
        end
      end
    end
  endtask

  task automatic test_reset;
    in_t ins[$]; logic [7:0] v[$];
    @(negedge CLK);
    nRST = 1'b0;
    apply(idle(1'b0));
    #1;
    checks++;
    if (obs_vec !== NOIHIT || halted !== 1'b0 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset: got vec=%b halted=%b stall=%0d, want vec=%b halted=0 stall=0",
               obs_vec, halted, stall_cycles, NOIHIT);
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin ins.push_back(idle(1'b1)); v.push_back(NORMAL); end
    run_steps("normal", ins, v);
  endtask

  task automatic test_load_use;
    in_t ins[$]; logic [7:0] v[$]; in_t a;
    a = idle(1'b1); a.ex_memread = 1; a.ex_rt = 5'd8; a.id_rs = 5'd8;
    ins.push_back(a); v.push_back(LU);
    ins.push_back(idle(1'b1)); v.push_back(NORMAL);
    a = idle(1'b1); a.ex_memread = 1; a.ex_rt = 5'd5; a.id_rs = 5'd3; a.id_rt = 5'd5; a.id_uses_rt = 1;
    ins.push_back(a); v.push_back(LU);
    a.id_uses_rt = 0;
    ins.push_back(a); v.push_back(NORMAL);
    a = idle(1'b1); a.ex_memread = 1; a.ex_rt = 5'd0; a.id_rs = 5'd0;
    ins.push_back(a); v.push_back(NORMAL);
    a = idle(1'b0); a.ex_memread = 1; a.ex_rt = 5'd9; a.id_rs = 5'd9;
    ins.push_back(a); v.push_back(LU);
    run_steps("load_use", ins, v);
  endtask

  task automatic test_dwait;
    in_t ins[$]; logic [7:0] v[$]; in_t a;
    a = idle(1'b1); a.mem_req = 1; a.dhit = 0;
    for (int k = 0; k < 3; k++) begin ins.push_back(a); v.push_back(FREEZE); end
    a.dhit = 1;
    ins.push_back(a); v.push_back(NORMAL);
    ins.push_back(idle(1'b1)); v.push_back(NORMAL);
    run_steps("dwait", ins, v);
  endtask

  task automatic test_redirect;
    in_t ins[$]; logic [7:0] v[$]; in_t a, d;
    a = idle(1'b0); a.br = 1;
    ins.push_back(a); v.push_back(BR);
    ins.push_back(idle(1'b0)); v.push_back(NOIHIT);
    ins.push_back(idle(1'b0)); v.push_back(NOIHIT);
    ins.push_back(idle(1'b1)); v.push_back(REDIR);
    ins.push_back(idle(1'b1)); v.push_back(NORMAL);
    // redirect with fetch already returned: no pending stale word
    a = idle(1'b1); a.br = 1; a.ex_memread = 1; a.ex_rt = 5'd4; a.id_rs = 5'd4;
    ins.push_back(a); v.push_back(BR);
    ins.push_back(idle(1'b1)); v.push_back(NORMAL);
    // pending stale fetch survives a data-memory freeze
    a = idle(1'b0); a.br = 1;
    ins.push_back(a); v.push_back(BR);
    d = idle(1'b1); d.mem_req = 1;
    ins.push_back(d); v.push_back(FREEZE);
    ins.push_back(idle(1'b0)); v.push_back(NOIHIT);
    ins.push_back(idle(1'b1)); v.push_back(REDIR);
    ins.push_back(idle(1'b1)); v.push_back(NORMAL);
    run_steps("redirect", ins, v);
  endtask

  task automatic test_halt;
    in_t ins[$]; logic [7:0] v[$]; in_t a;
    a = idle(1'b1); a.halt = 1; a.mem_req = 1; a.br = 1;
    ins.push_back(a); v.push_back(FREEZE);
    for (int k = 0; k < 10; k++) begin ins.push_back(idle(1'b1)); v.push_back(FREEZE); end
    run_steps("halt", ins, v);
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || stall_cycles !== 16'd0 || obs_vec !== NORMAL) begin
      errors++;
      $display("FAIL async_reset: got halted=%b stall=%0d vec=%b, want halted=0 stall=0 vec=%b",
               halted, stall_cycles, obs_vec, NORMAL);
    end
    m_stall = 0; m_halted = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_saturation;
    in_t ins[$]; logic [7:0] v[$];
    do_reset();
    for (int k = 0; k < 20; k++) begin ins.push_back(idle(1'b0)); v.push_back(NOIHIT); end
    run_steps("sat_main", ins, v);
    checks++;
    if (s_stall !== 4'd15) begin
      errors++;
      $display("FAIL saturation: got %0d, want 15", s_stall);
    end
    @(negedge CLK);
    checks++;
    if (s_stall !== 4'd15) begin
      errors++;
      $display("FAIL saturation_hold: got %0d, want 15", s_stall);
    end
  endtask

  initial begin
    nRST = 1'b1;
    apply(idle(1'b1));
    m_stall = 0; m_halted = 1'b0;
    test_reset();
    test_load_use();
    test_dwait();
    test_redirect();
    test_halt();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
